ps_tx_scheduler: RTL and testbench
==================================

Name: ps_tx_scheduler

Overview:
- Sequences and shares the single parallel-to-serial transmitter between two byte-stream requesters (lane controller, 0; diagnostic/test source, 1).
- After reset, holds the link in training for a fixed count of COM (8'hBC) symbol periods.
- Then grants the serializer in bursts with round-robin arbitration and a fairness cap.
- Drives the serializer's 8-bit data_in/valid_in pair at the parallel (clk4_f) rate.

Parameters:
- TRAIN_CYCLES, 16, clk4_f cycles of forced COM after reset before any grant (1..255).
- MAX_BURST, 8, maximum bytes per grant before forced re-arbitration (1..255).
- COM_SYM, 8'hBC, symbol driven on ser_data while no byte is valid.

Ports:
- clk4_f  input  1  parallel-rate clock; all logic rising-edge.
- reset_L  input  1  asynchronous, active-low reset.
- req0_valid  input  1  source 0 has a byte.
- req0_data  input  8  source 0 byte.
- req0_last  input  1  byte is last of source 0 burst.
- req0_ready  output  1  source 0 byte accepted this cycle.
- req1_valid, req1_data, req1_last, req1_ready: same as source 0, for source 1.
- ser_data  output  8  to serializer data_in.
- ser_valid  output  1  to serializer valid_in.
- train_done  output  1  high once training is complete.
- grant  output  2  one-hot current owner; 2'b00 when none.

Behaviour:
- Reset (async on reset_L low, released synchronously in effect at the next edge):
  - state=TRAIN; ser_data=COM_SYM, ser_valid=0; train_done=0; grant=0; req*_ready=0.
  - Counters cleared; round-robin pointer set to favour source 0.
- Transfer rule: a handshake occurs when reqN_valid & reqN_ready are both high at a clk4_f edge.
  - reqN_ready is combinational: 1 only when state=BURST, grant[N]=1, and the burst count is below MAX_BURST.
- Latency: an accepted byte appears on ser_data with ser_valid=1 on the next cycle (registered outputs, 1 cycle).
- Any cycle without a handshake: next cycle ser_valid=0, ser_data=COM_SYM.
- States:
  - TRAIN: count cycles; when the count reaches TRAIN_CYCLES-1, go to IDLE and set train_done=1. train_done stays high until reset. Requests are ignored during TRAIN.
  - IDLE: arbitrate.
    - One requester valid: grant it.
    - Both valid: grant the one indicated by the round-robin pointer.
    - Neither valid: stay in IDLE.
    - Grant registers on the edge; go to BURST with burst count=0. No byte is accepted in the granting cycle, so there is one bubble per grant.
  - BURST: on each handshake, increment the burst count. Release (grant=0, pointer to the other source, go to IDLE) when either:
    - the accepted byte has last=1, or
    - the count reaches MAX_BURST.
  - Owner drops valid mid-burst: stay in BURST, emit COM bubbles, keep the grant. There is no timeout.
- Simultaneous last and MAX_BURST on the same byte: a single release; the pointer flips once.
- Burst count is 8 bits; compare with == MAX_BURST, so no wrap.
- Non-owner valid is ignored and its ready is 0.
- Reset mid-burst: immediate abort to TRAIN. The partial burst is lost; the source must resend.

Decomposition:
- Shared package ps_pkg: COM_SYM localparam (8'hBC), state encoding (TRAIN, IDLE, BURST as 2-bit constants), grant one-hot constants.
- One sub-module: ps_rr_arbiter, a 2-way round-robin arbiter. Inputs: req[1:0], pointer, update strobe. Outputs: one-hot gnt.
- Pair with the existing Probador style: a probador_ps_tx_scheduler module driving clocks and stimulus.

Test Plan:
- Reset, both requesters valid throughout -> ser_valid=0 and ser_data=8'hBC for exactly 16 cycles; train_done rises on cycle 16; grant=2'b01 on cycle 17.
- Source 0 sends FF,EE,00 with last on 00, source 1 idle -> ser_data FF,EE,00 with ser_valid=1 on consecutive cycles starting one cycle after the first ready; then BC; grant returns to 00.
- Both continuously valid, no last, MAX_BURST=8 -> grant alternates 01/10. Each burst is exactly 8 bytes separated by one BC bubble. Ready is never high for both sources.
- Owner deasserts valid for 3 cycles mid-burst -> 3 BC cycles with ser_valid=0; grant held; burst resumes; byte count is unaffected.
- Byte 8 carries last=1 -> single release; next grant goes to the other source.
- reset_L pulsed low mid-burst, asynchronously between edges -> outputs return to reset values immediately; TRAIN restarts with a full 16-cycle COM period.

Source files
------------

// File: rtl/ps_pkg.sv
// Shared constants for the parallel-to-serial transmit scheduler:
// idle symbol, scheduler state encoding and one-hot grant codes.
package ps_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;

  typedef enum logic [1:0] {
    ST_TRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BURST = 2'd2
  } ps_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_SRC0 = 2'b01;
  localparam logic [1:0] GNT_SRC1 = 2'b10;

endpackage

// File: rtl/ps_rr_arbiter.sv
// Two-way round-robin arbiter: combinational one-hot pick, with a pointer
// that moves to the other source whenever a burst owner is released.
module ps_rr_arbiter
  import ps_pkg::*;
(
  input  logic       clk4_f,
  input  logic       reset_L,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       owner,
  output logic [1:0] gnt
);

  logic pointer;

  // Pointer favours source 0 out of reset and flips away from the released owner.
  always_ff @(posedge clk4_f or negedge reset_L) begin
    if (!reset_L) begin
      pointer <= 1'b0;
    end else if (update) begin
      pointer <= ~owner;
    end
  end

  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_SRC0;
      2'b10:   gnt = GNT_SRC1;
      2'b11:   gnt = pointer ? GNT_SRC1 : GNT_SRC0;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/ps_tx_scheduler.sv
// Shares one serializer between two byte sources: a COM training period after
// reset, then round-robin bursts capped at MAX_BURST bytes each.
module ps_tx_scheduler
  import ps_pkg::*;
#(
  parameter int TRAIN_CYCLES = 16,
  parameter int MAX_BURST    = 8
) (
  input  logic       clk4_f,
  input  logic       reset_L,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] ser_data,
  output logic       ser_valid,
  output logic       train_done,
  output logic [1:0] grant
);

  localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_CYCLES - 1);
  localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);

  ps_state_t  state;
  logic [7:0] train_cnt;
  logic [7:0] burst_cnt;
  logic [7:0] burst_inc;
  logic [1:0] arb_gnt;
  logic       in_burst;
  logic       hs0;
  logic       hs1;
  logic       hs;
  logic       hs_last;
  logic [7:0] hs_data;
  logic       release_now;

  assign in_burst   = (state == ST_BURST) && (burst_cnt < BURST_MAX);
  assign req0_ready = in_burst && grant[0];
  assign req1_ready = in_burst && grant[1];

  assign hs0       = req0_valid && req0_ready;
  assign hs1       = req1_valid && req1_ready;
  assign hs        = hs0 || hs1;
  assign hs_data   = hs1 ? req1_data : req0_data;
  assign hs_last   = hs1 ? req1_last : req0_last;
  assign burst_inc = burst_cnt + 8'd1;

  // Last byte and the burst cap can coincide; both fold into one release.
  assign release_now = hs && (hs_last || (burst_inc == BURST_MAX));

  ps_rr_arbiter u_arb (
    .clk4_f  (clk4_f),
    .reset_L (reset_L),
    .req     ({req1_valid, req0_valid}),
    .update  (release_now),
    .owner   (grant[1]),
    .gnt     (arb_gnt)
  );

  // Scheduler FSM; every output is registered so bytes appear one cycle after acceptance.
  always_ff @(posedge clk4_f or negedge reset_L) begin
    if (!reset_L) begin
      state      <= ST_TRAIN;
      train_cnt  <= 8'd0;
      burst_cnt  <= 8'd0;
      ser_data   <= COM_SYM;
      ser_valid  <= 1'b0;
      train_done <= 1'b0;
      grant      <= GNT_NONE;
    end else begin
      ser_data  <= COM_SYM;
      ser_valid <= 1'b0;
      case (state)
        ST_TRAIN: begin
          if (train_cnt == TRAIN_LAST) begin
            state      <= ST_IDLE;
            train_done <= 1'b1;
          end else begin
            train_cnt <= train_cnt + 8'd1;
          end
        end
        ST_IDLE: begin
          if (arb_gnt != GNT_NONE) begin
            grant     <= arb_gnt;
            burst_cnt <= 8'd0;
            state     <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (hs) begin
            ser_data  <= hs_data;
            ser_valid <= 1'b1;
            burst_cnt <= burst_inc;
            if (release_now) begin
              grant <= GNT_NONE;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_TRAIN;
      endcase
    end
  end

endmodule

// File: tb/tb_ps_tx_scheduler.sv
// Randomised scoreboard bench for ps_tx_scheduler against a behavioural
// model of training, round-robin grants and capped bursts.
module tb_ps_tx_scheduler;

  localparam int TRAIN = 16;
  localparam int MAXB  = 8;

  logic       clk4_f = 1'b0;
  logic       reset_L = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_last = 1'b0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_last = 1'b0;
  logic       req1_ready;
  logic [7:0] ser_data;
  logic       ser_valid;
  logic       train_done;
  logic [1:0] grant;

  always #5 clk4_f = ~clk4_f;

  ps_tx_scheduler #(.TRAIN_CYCLES(TRAIN), .MAX_BURST(MAXB)) dut (
    .clk4_f     (clk4_f),
    .reset_L    (reset_L),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .ser_data   (ser_data),
    .ser_valid  (ser_valid),
    .train_done (train_done),
    .grant      (grant)
  );

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic [1:0] g;
    logic       td;
  } exp_t;

  exp_t sbq[$];
  int   compared = 0;
  int   mismatched = 0;
  bit   run_active = 0;

  // Reference model: phase 0 training, 1 waiting for a requester, 2 owner streaming.
  int m_phase, m_elapsed, m_owner, m_count, m_ptr;
  bit m_tdone;

  task automatic modelReset();
    m_phase   = 0;
    m_elapsed = 0;
    m_owner   = -1;
    m_count   = 0;
    m_ptr     = 0;
    m_tdone   = 0;
  endtask

  function automatic logic [1:0] grantOf(int o);
    if (o < 0) return 2'b00;
    return (o == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input int pv, input int pl);
    bit   mr0, mr1, hs, lst;
    logic [7:0] dat;
    exp_t e;
    req0_valid = ($urandom_range(0, 99) < pv);
    req0_data  = 8'($urandom);
    req0_last  = ($urandom_range(0, 99) < pl);
    req1_valid = ($urandom_range(0, 99) < pv);
    req1_data  = 8'($urandom);
    req1_last  = ($urandom_range(0, 99) < pl);
    #1;
    mr0 = (m_phase == 2) && (m_owner == 0) && (m_count < MAXB);
    mr1 = (m_phase == 2) && (m_owner == 1) && (m_count < MAXB);
    checkOutput("ready", 32'({req1_ready, req0_ready}), 32'({mr1, mr0}));
    checkOutput("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
    hs  = (req0_valid && mr0) || (req1_valid && mr1);
    dat = mr1 ? req1_data : req0_data;
    lst = mr1 ? req1_last : req0_last;
    e.v = 1'b0;
    e.d = 8'hBC;
    case (m_phase)
      0: begin
        m_elapsed++;
        if (m_elapsed == TRAIN) begin
          m_phase = 1;
          m_tdone = 1;
        end
      end
      1: begin
        if (req0_valid || req1_valid) begin
          m_owner = (req0_valid && req1_valid) ? m_ptr : (req0_valid ? 0 : 1);
          m_count = 0;
          m_phase = 2;
        end
      end
      default: begin
        if (hs) begin
          e.v = 1'b1;
          e.d = dat;
          m_count++;
          if (lst || m_count == MAXB) begin
            m_ptr   = 1 - m_owner;
            m_owner = -1;
            m_phase = 1;
          end
        end
      end
    endcase
    e.g  = grantOf(m_owner);
    e.td = m_tdone;
    sbq.push_back(e);
    @(negedge clk4_f);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ser_valid"}, 32'(ser_valid), 32'd0);
    checkOutput({tag, "_ser_data"}, 32'(ser_data), 32'hBC);
    checkOutput({tag, "_train_done"}, 32'(train_done), 32'd0);
    checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
    checkOutput({tag, "_ready"}, 32'({req1_ready, req0_ready}), 32'd0);
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk4_f);
      #1;
      if (run_active) begin
        if (sbq.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL sb_underflow: got no entry expected one at %0t", $time);
        end else begin
          e = sbq.pop_front();
          checkOutput("ser_out", 32'({ser_valid, ser_data, grant, train_done}), 32'(e));
        end
      end
    end
  end

  initial begin
    bit did_reset = 0;
    repeat (3) @(negedge clk4_f);
    checkResetState("por");
    reset_L = 1'b1;
    modelReset();
    run_active = 1;
    for (int i = 0; i < 700; i++) begin
      if (i >= 460 && m_phase == 2 && !did_reset) begin
        did_reset = 1;
        #1 reset_L = 1'b0;
        #1 checkResetState("mid_reset");
        #1 reset_L = 1'b1;
        modelReset();
      end
      if (i < 80)       applyStimulus(100, 0);
      else if (i < 300) applyStimulus(70, 15);
      else if (i < 450) applyStimulus(50, 5);
      else              applyStimulus(90, 10);
    end
    run_active = 0;
    if (!did_reset) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL mid_reset_reach: got no burst expected one before cycle 700");
    end
    @(negedge clk4_f);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
